// File: rtl/counter_sched.sv
// ---------------------------------------------------------------------------
// counter_sched
//
// Sequencing controller for a basic up-counter. The block owns a WIDTH-bit
// count register and decides when it clears, advances, holds and wraps. It
// provides start/stop/pause control, a programmable terminal period, one-shot
// or periodic operation, and a one-cycle tick at each period boundary.
//
// Ports:
//   clk      in   1      system clock, all state changes on the rising edge
//   rst      in   1      asynchronous active-low reset (0 = in reset)
//   start    in   1      loads period/mode and (re)starts counting
//   stop     in   1      abort, return to IDLE (wins over start)
//   pause    in   1      freezes counting while high in RUN/HOLD
//   incr     in   1      count enable / prescaler strobe
//   mode     in   1      0 = one-shot, 1 = periodic (sampled with start)
//   period   in   WIDTH  terminal count, 1..2^WIDTH-1 (sampled with start)
//   cnt_out  out  WIDTH  current count, 0..period_q-1
//   tick     out  1      one-cycle pulse on period completion
//   done     out  1      high in DONE (one-shot finished)
//   busy     out  1      high in RUN or HOLD
//   err      out  1      one-cycle pulse when a start with period=0 is rejected
// ---------------------------------------------------------------------------
module counter_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             incr,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  logic [WIDTH-1:0] period_q;
  logic             mode_q;

  // Terminal value of the count for the captured period. period_q is never 0
  // while counting, so this never underflows in RUN.
  logic [WIDTH-1:0] last_cnt;
  logic             at_last;

  assign last_cnt = period_q - ONE;
  assign at_last  = (cnt_out == last_cnt);

  // Single registered FSM. Per-cycle priority is stop > start > pause > incr.
  // busy/done are registered alongside the state so they change on the same
  // edge as the state transition. tick and err default low so each is a
  // one-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt_out  <= ZERO;
      period_q <= ZERO;
      mode_q   <= 1'b0;
      tick     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      tick <= 1'b0;
      err  <= 1'b0;

      if (stop) begin
        state   <= IDLE;
        cnt_out <= ZERO;
        done    <= 1'b0;
        busy    <= 1'b0;
      end else if (start) begin
        // A zero period is rejected without disturbing the current state or
        // count; the start cycle never counts, even with incr high.
        if (period != ZERO) begin
          period_q <= period;
          mode_q   <= mode;
          cnt_out  <= ZERO;
          state    <= RUN;
          done     <= 1'b0;
          busy     <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            cnt_out <= ZERO;
          end

          RUN: begin
            if (pause) begin
              state <= HOLD;
            end else if (incr) begin
              if (at_last) begin
                // Wrap and tick on the same edge; one-shot ends here.
                cnt_out <= ZERO;
                tick    <= 1'b1;
                if (!mode_q) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                end
              end else begin
                cnt_out <= cnt_out + ONE;
              end
            end
          end

          HOLD: begin
            // The release edge only changes state; counting picks up on the
            // next incr seen in RUN.
            if (!pause) begin
              state <= RUN;
            end
          end

          DONE: begin
            cnt_out <= ZERO;
          end

          default: begin
            state   <= IDLE;
            cnt_out <= ZERO;
            done    <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Sequencing controller for the basic up-counter datapath: owns an internal WIDTH-bit count register and decides when it clears, advances, holds and wraps.
- Provides start/stop/pause control, a programmable terminal period, one-shot or periodic operation, and a one-cycle tick at each period boundary.
- Sits between software-visible control registers and the logic that consumes periodic events (timeouts, sample strobes).

Parameters:
- WIDTH, 8, width of count, period and cnt_out.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  level, sampled each cycle; loads period/mode and (re)starts counting.
- stop  in  1  abort; returns the block to IDLE.
- pause  in  1  level; freezes counting while high in RUN/HOLD.
- incr  in  1  count enable / prescaler strobe; count advances only on cycles with incr=1.
- mode  in  1  0 = one-shot, 1 = periodic; sampled with start.
- period  in  WIDTH  terminal count; valid range 1..2^WIDTH-1; sampled with start.
- cnt_out  out  WIDTH  current count, range 0..period_q-1.
- tick  out  1  one-cycle pulse on period completion.
- done  out  1  high in DONE state (one-shot finished).
- busy  out  1  high in RUN or HOLD.
- err  out  1  one-cycle pulse when start is rejected (period=0).

Behaviour:
- All outputs registered. Async reset (rst=0): state=IDLE, cnt_out=0, tick=0, done=0, busy=0, err=0, period_q=0, mode_q=0.
- States: IDLE, RUN, HOLD, DONE. busy=1 in RUN/HOLD; done=1 in DONE only.
- Priority per cycle: stop > start > pause > incr.
- stop=1 (any state): next state IDLE, cnt_out<=0, tick/err=0. Takes priority over a simultaneous start.
- start=1, period!=0 (any state, including RUN/HOLD = retrigger): period_q<=period, mode_q<=mode, cnt_out<=0, next state RUN. No count on the start cycle, even if incr=1.
- start=1, period=0: state and cnt_out unchanged; err=1 for the following cycle.
- RUN, pause=1: next state HOLD; cnt_out frozen; incr ignored.
- HOLD, pause=0: next state RUN; counting resumes on the next incr.
- HOLD: start and stop are still honoured.
- RUN, pause=0, incr=1, cnt_out != period_q-1: cnt_out<=cnt_out+1.
- RUN, pause=0, incr=1, cnt_out == period_q-1: cnt_out<=0 and tick=1 for one cycle (same edge).
  - mode_q=1: stay RUN.
  - mode_q=0: next state DONE.
- period_q=1: a tick occurs on every incr cycle; cnt_out stays 0.
- DONE: cnt_out=0, done=1 until start (restart) or stop (to IDLE). incr/pause ignored.
- IDLE: incr/pause ignored; cnt_out holds 0.
- Count never exceeds period_q-1; no arithmetic overflow is possible because period_q <= 2^WIDTH-1.
- Latency: start to first possible increment is 1 cycle. Last incr to tick-high is 1 clock edge.
- Reset mid-operation: immediate return to reset values regardless of state; the first edge after rst deasserts is evaluated as IDLE.
- period and mode changes while running have no effect until the next accepted start.

Test Plan (WIDTH=8):
- Reset then idle: rst=0 for 2 cycles, then rst=1, incr=1 for 5 cycles -> cnt_out=0, busy=0, tick=0, done=0 throughout.
- Periodic: start with period=4, mode=1, then incr=1 continuously for 12 cycles -> cnt_out sequence 0,1,2,3,0,…; tick high exactly 3 times, each on the cycle cnt_out returns to 0; busy=1.
- One-shot plus gated incr: period=3, mode=0, incr toggling 1/0 -> cnt_out 0,1,1,2,2,0; one tick, then done=1, busy=0; further incr leaves cnt_out=0.
- Pause: periodic period=10, pause high after cnt_out=5 for 4 cycles with incr=1 -> cnt_out holds 5, state HOLD; after release cnt_out 6,7,…
- Priorities:
  - start and stop in the same cycle while RUN -> IDLE, cnt_out=0.
  - Retrigger: start with period=2 while RUN at cnt_out=7 -> cnt_out=0, new period 2 in effect.
  - start with period=0 -> err pulses 1 cycle, state unchanged.
- Async reset mid-count: rst=0 between clock edges at cnt_out=6 -> cnt_out=0, busy=0 immediately, without waiting for a clock edge.
